// File: rtl/sw_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_fifo_pkg
//  Description : Shared definitions for the Smith-Waterman stage FIFO.
//                Holds the default data width and depth of the original
//                fixed score/traceback FIFO and a constant-foldable ceil-log2
//                helper used to size pointers and the occupancy counter.
//
//                Compile-time option SW_FIFO_FWFT_EN:
//                  defined   -> first-word-fall-through read mode; dout shows
//                               the head entry combinationally while not
//                               empty and rd_en pops it.
//                  undefined -> registered read; dout updates on the edge a
//                               read is accepted (1-cycle latency), resets
//                               to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
package sw_fifo_pkg;

    localparam int DEFAULT_WIDTH = 18;
    localparam int DEFAULT_DEPTH = 16;

    // Ceil(log2(n)) for n >= 1; returns 0 for n <= 1.
    function automatic int sw_clog2(input int n);
        int v;
        int r;
        v = n - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : sw_fifo_pkg
`default_nettype wire

// File: rtl/sw_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sw_fifo_ram
//  Description : Simple dual-port storage for sw_sync_fifo. One synchronous
//                write port, one asynchronous read port, no reset on the
//                array (contents are never exposed while the FIFO is empty).
//  Ports       : clk         - write clock
//                i_we        - write enable
//                i_waddr     - write address
//                i_wdata     - write data
//                i_raddr     - read address
//                o_rdata     - read data (combinational from i_raddr)
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_fifo_ram
    import sw_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = sw_clog2(DEFAULT_DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : sw_fifo_ram
`default_nettype wire

// File: rtl/sw_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sw_sync_fifo
//  Description : Parametrised single-clock FIFO between Smith-Waterman
//                pipeline stages. Occupancy is tracked in a dedicated counter
//                and every flag is registered from the next-count value, so
//                no output has a combinational path from wr_en/rd_en.
//                Compile-time macro SW_FIFO_FWFT_EN selects first-word-fall-
//                through reads; otherwise reads are registered (1 cycle).
//  Ports       : clk, rst      - clock, async active-high reset
//                din, wr_en    - write data / request
//                rd_en         - read request
//                dout          - read data
//                full, empty   - count == DEPTH / count == 0
//                almost_full   - count >= AFULL_THRESH
//                almost_empty  - count <= AEMPTY_THRESH
//                count         - occupancy 0..DEPTH
//                overflow      - 1-cycle pulse after a rejected write
//                underflow     - 1-cycle pulse after a read while empty
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_sync_fifo
    import sw_fifo_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = sw_clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] c_AFULL_TH  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] c_AEMPTY_TH = CW'(AEMPTY_THRESH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             r_afull;
    logic             r_aempty;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_rd_data;

    // Acceptance uses the registered flags only; when full the read side
    // frees a slot but the write in that same cycle is still rejected.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_nxt;
            // Flags follow the count that is being registered this edge.
            r_full      <= (w_count_nxt == c_DEPTH_CNT);
            r_empty     <= (w_count_nxt == '0);
            r_afull     <= (w_count_nxt >= c_AFULL_TH);
            r_aempty    <= (w_count_nxt <= c_AEMPTY_TH);
            r_overflow  <= wr_en & r_full;
            r_underflow <= rd_en & r_empty;
        end
    end

    sw_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

`ifdef SW_FIFO_FWFT_EN
    // Head entry is presented directly; rd_en only advances the pointer.
    assign dout = w_rd_data;
`else
    logic [WIDTH-1:0] r_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= w_rd_data;
        end
    end

    assign dout = r_dout;
`endif

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : sw_sync_fifo
`default_nettype wire

// File: tb/tb_sw_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_sync_fifo
//  Description : Self-checking bench for sw_sync_fifo. A queue-based model
//                tracks FIFO contents; expected flags are derived from the
//                queue size each cycle. Directed scenarios plus a randomized
//                traffic phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_sync_fifo;

    localparam int WIDTH  = 18;
    localparam int DEPTH  = 16;
    localparam int AFULL  = DEPTH - 2;
    localparam int AEMPTY = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       count;
    logic             overflow;
    logic             underflow;

    sw_sync_fifo #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AFULL),
        .AEMPTY_THRESH (AEMPTY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_ovf;
    logic             exp_unf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count",        32'(count),        32'(n));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= AFULL));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY));
        chk("overflow",     32'(overflow),     32'(exp_ovf));
        chk("underflow",    32'(underflow),    32'(exp_unf));
`ifdef SW_FIFO_FWFT_EN
        if (n != 0) chk("dout_fwft", 32'(dout), 32'(q[0]));
`else
        chk("dout", 32'(dout), 32'(exp_dout));
`endif
    endtask

    // One clock of traffic: drive, advance the model at the edge, check.
    task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        bit was_full;
        bit was_empty;
        wr_en = wr;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        exp_ovf   = wr && was_full;
        exp_unf   = rd && was_empty;
        if (rd && !was_empty) exp_dout = q.pop_front();
        if (wr && !was_full)  q.push_back(d);
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rnd_data();
        return WIDTH'($urandom);
    endfunction

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single write then read of 5
        step(1'b1, 1'b0, 18'd5);
        step(1'b0, 1'b1, '0);

        // Fill 0..15, overflow on the 17th write, drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(i));
        step(1'b1, 1'b0, 18'h2AAAA);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);

        // Underflow while empty
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Steady simultaneous traffic at count 8, pointers wrap twice
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, rnd_data());
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, rnd_data());

        // Full with both requests, then empty with both requests
        while (q.size() < DEPTH) step(1'b1, 1'b0, rnd_data());
        step(1'b1, 1'b1, rnd_data());
        while (q.size() > 0) step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, rnd_data());
        step(1'b0, 1'b1, '0);

        // Randomized traffic alternating write-heavy and read-heavy phases
        for (int i = 0; i < 400; i++) begin
            int pw;
            pw = ((i / 50) % 2 == 0) ? 75 : 25;
            step($urandom_range(99) < pw, $urandom_range(99) < (100 - pw), rnd_data());
        end
        while (q.size() > 0) step(1'b0, 1'b1, '0);

        // Asynchronous reset mid-burst at count 9
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, rnd_data());
        wr_en = 1'b1;
        din   = rnd_data();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        step(1'b1, 1'b0, 18'h3FFFF);
        step(1'b0, 1'b1, '0);
        chk("post_reset_data", 32'(exp_dout), 32'h3FFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_sw_sync_fifo
`default_nettype wire

// File: doc/sw_sync_fifo.md
# sw_sync_fifo

Parametrised single-clock FIFO that replaces the fixed 18-bit test FIFO used between Smith-Waterman pipeline stages (score/traceback streams to the host interface). Adds configurable width and depth, occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. Optional first-word-fall-through (FWFT) read mode is selectable at compile time.

## Interface
- WIDTH, 18, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AFULL_THRESH, DEPTH-2, almost_full asserted when count ≥ this value
- AEMPTY_THRESH, 2, almost_empty asserted when count ≤ this value
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous assert, active-high; synchronous release to clk is the integrator's job
- din  in  WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- dout  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THRESH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: wr_en while full and write rejected
- underflow  out  1  one-cycle pulse: rd_en while empty

## Operation
- Write accepted iff wr_en && !full; din stored at wr_ptr, wr_ptr increments.
- Read accepted iff rd_en && !empty; rd_ptr increments.
- Pointers are $clog2(DEPTH) bits, wrap DEPTH-1 → 0 naturally; count is tracked separately (no pointer-compare flag logic).
- count next = count + wr_acc − rd_acc; simultaneous accepted read and write leaves count unchanged.
- Full and rd_en && wr_en: read accepted, write rejected, overflow pulses; count becomes DEPTH−1.
- Empty and rd_en && wr_en: write accepted, read rejected, underflow pulses; count becomes 1.
- All flags derive from registered count (full/empty/almost_* registered alongside count, no combinational path from wr_en/rd_en).
- Reset (any time, including mid-burst): pointers, count = 0; empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, dout = 0. Memory contents not cleared; stale data never visible since empty = 1.

## Timing
- Write at edge N → count/empty/almost flags reflect it after edge N.
- Standard mode: dout registered; updated at the edge where a read is accepted, holds otherwise. Read latency 1 cycle (rd_en at edge N, data valid after edge N).
- FWFT mode: dout = mem[rd_ptr] combinationally whenever empty = 0; rd_en acknowledges/pops current word. First word visible the cycle after its write edge. dout undefined-but-stable (don't care) while empty = 1.
- overflow/underflow: registered, high for exactly the one cycle following the offending edge.

## Configuration
- SW_FIFO_FWFT_EN defined: first-word-fall-through read mode as above; dout register removed.
- SW_FIFO_FWFT_EN undefined: standard registered-read mode, 1-cycle read latency, dout resets to 0.
- Flags, count, error pulses identical in both modes.

## Structure
- Shared package/header sw_fifo_pkg: default WIDTH/DEPTH constants, clog2 helper, SW_FIFO_FWFT_EN documentation.
- One sub-module: sw_fifo_ram — simple dual-port memory (one write port, one asynchronous read port), no reset, WIDTH × DEPTH; FIFO control lives in sw_sync_fifo.

## Test plan
- Reset then write 5 (wr_en one cycle), rd_en next cycle → dout = 5 (standard: after the read edge; FWFT: visible before rd_en), empty back to 1, count 1 → 0.
- Write 0..15 with DEPTH=16 → full = 1, count = 16, almost_full from count 14; 17th write → overflow pulse, count stays 16; read all 16 → 0..15 in order.
- Read while empty → underflow one-cycle pulse, count 0, pointers unchanged.
- Continuous simultaneous read+write at count 8 for 40 cycles (pointer wrap ×2) → count constant 8, data order preserved.
- Full with rd_en && wr_en → read data = oldest word, overflow = 1, count = 15; empty with both → count = 1, underflow = 1.
- Assert rst mid-burst at count 9 → all outputs to reset values immediately (asynchronously), next write/read of 0x3FFFF returns 0x3FFFF.
